// File: rtl/regbus_pkg.sv
// Shared definitions for the internal data-bus sequencer: FSM states,
// default geometry and symbolic register-file indices.
package regbus_pkg;

  localparam int unsigned DEF_NREG  = 8;
  localparam int unsigned DEF_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  localparam int unsigned REG_B = 0;
  localparam int unsigned REG_C = 1;
  localparam int unsigned REG_D = 2;
  localparam int unsigned REG_E = 3;
  localparam int unsigned REG_H = 4;
  localparam int unsigned REG_L = 5;
  localparam int unsigned REG_A = 6;
  localparam int unsigned REG_F = 7;

endpackage

// File: rtl/regbus_ctrl_onehot_dec.sv
// Index to one-hot decoder with enable; indices beyond NREG-1 decode to zero.
module onehot_dec #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [NREG-1:0]  y
);

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      y[i] = en && (32'(idx) == i);
    end
  end

endmodule

// File: rtl/regbus_ctrl.sv
// Register-transfer sequencer for the shared 8-bit bus: one command at a time,
// two-cycle drive (settle + latch) followed by an undriven turnaround cycle.
module regbus_ctrl
  import regbus_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_src,
  input  logic             req_ext,
  input  logic [IDX_W-1:0] req_dst,
  output logic [NREG-1:0]  oe,
  output logic [NREG-1:0]  wr,
  output logic             ext_oe,
  output logic             done,
  output logic             err
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] src_q, dst_q, src_n, dst_n;
  logic             ext_q, ill_q, ext_n, ill_n;
  logic             accept, req_ill, req_trivial;
  logic             drive_n, oe_en, wr_en;
  logic [NREG-1:0]  oe_n, wr_n;
  logic             ext_oe_n, done_n, err_n;

  assign req_ready   = (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign req_ill     = (!req_ext && (32'(req_src) >= NREG)) || (32'(req_dst) >= NREG);
  assign req_trivial = !req_ext && (req_src == req_dst);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (req_ill || req_trivial) ? ST_TURN : ST_DRIVE;
        end
      end
      ST_DRIVE: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_TURN;
      ST_TURN:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are flopped, so decode from the fields that will be held after
  // this edge: the live request on accept, the captured copy otherwise.
  always_comb begin
    src_n    = accept ? req_src : src_q;
    dst_n    = accept ? req_dst : dst_q;
    ext_n    = accept ? req_ext : ext_q;
    ill_n    = accept ? req_ill : ill_q;
    drive_n  = (state_nxt == ST_DRIVE) || (state_nxt == ST_LATCH);
    oe_en    = drive_n && !ext_n;
    ext_oe_n = drive_n && ext_n;
    wr_en    = (state_nxt == ST_LATCH);
    done_n   = (state_nxt == ST_TURN);
    err_n    = done_n && ill_n;
  end

  onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_oe_dec (
    .en  (oe_en),
    .idx (src_n),
    .y   (oe_n)
  );

  onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_wr_dec (
    .en  (wr_en),
    .idx (dst_n),
    .y   (wr_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      ext_q  <= 1'b0;
      ill_q  <= 1'b0;
      oe     <= '0;
      wr     <= '0;
      ext_oe <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      src_q  <= src_n;
      dst_q  <= dst_n;
      ext_q  <= ext_n;
      ill_q  <= ill_n;
      oe     <= oe_n;
      wr     <= wr_n;
      ext_oe <= ext_oe_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_regbus_ctrl.sv
// Self-checking bench: bus-attached register file driven by the strobes,
// compared against a command-level model of the register contents.
module tb_regbus_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       req_valid, req_ready, req_ext, ext_oe, done, err;
  logic [2:0] req_src, req_dst;
  logic [7:0] oe, wr;

  logic       req_valid2, req_ready2, req_ext2, ext_oe2, done2, err2;
  logic [3:0] req_src2, req_dst2;
  logic [7:0] oe2, wr2;

  logic [7:0] ext_data;
  logic [7:0] rf [8];
  logic [7:0] model [8];
  logic [7:0] load_val [8];
  logic       load_en;
  logic [7:0] bus;
  logic       driven;

  int n_cmp = 0;
  int n_fail = 0;
  int viol = 0;
  int err1_cnt = 0;

  always #5 clk = ~clk;

  regbus_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_ext(req_ext), .req_dst(req_dst),
    .oe(oe), .wr(wr), .ext_oe(ext_oe), .done(done), .err(err)
  );

  regbus_ctrl #(.NREG(8), .IDX_W(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_src(req_src2), .req_ext(req_ext2), .req_dst(req_dst2),
    .oe(oe2), .wr(wr2), .ext_oe(ext_oe2), .done(done2), .err(err2)
  );

  // Tri-state bus and register file as seen from the bus side.
  always_comb begin
    bus = 8'h00;
    driven = 1'b0;
    if (ext_oe) begin
      bus = ext_data;
      driven = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      if (oe[i]) begin
        bus = rf[i];
        driven = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (load_en) rf[i] <= load_val[i];
      else if (wr[i]) rf[i] <= driven ? bus : 8'hEE;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (($countones(oe) + 32'(ext_oe)) > 1 || $countones(wr) > 1 || (wr & oe) != 0) viol++;
      if (($countones(oe2) + 32'(ext_oe2)) > 1 || $countones(wr2) > 1 || (wr2 & oe2) != 0) viol++;
      if (err) err1_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [7:0] base);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      load_val[i] = base + 8'(i * 17);
      model[i] = load_val[i];
    end
    load_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  function automatic logic is_move(input logic e, input logic [2:0] s, input logic [2:0] d);
    return e || (s != d);
  endfunction

  function automatic void model_apply(input logic e, input logic [2:0] s, input logic [2:0] d,
                                      input logic [7:0] data);
    if (is_move(e, s, d)) model[d] = e ? data : model[s];
  endfunction

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic issue(input logic e, input logic [2:0] s, input logic [2:0] d, input logic [7:0] data);
    int unsigned n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready_timeout", 32'(n), 32'd0);
    req_valid = 1'b1;
    req_ext = e;
    req_src = s;
    req_dst = d;
    ext_data = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_src = 3'($urandom);
    req_dst = 3'($urandom);
    req_ext = 1'($urandom);
  endtask

  task automatic issue2(input logic e, input logic [3:0] s, input logic [3:0] d);
    int unsigned n = 0;
    while (!req_ready2 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready2_timeout", 32'(n), 32'd0);
    req_valid2 = 1'b1;
    req_ext2 = e;
    req_src2 = s;
    req_dst2 = d;
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 1'b0;
  endtask

  typedef struct {
    logic       ext;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] data;
    logic       trivial;
    logic [7:0] exp_oe;
    logic       exp_ext;
    logic [7:0] exp_wr;
  } vec_t;

  typedef struct {
    logic       ext;
    logic [3:0] src;
    logic [3:0] dst;
  } ill_t;

  initial begin
    vec_t tbl[6];
    ill_t ill[3];
    int k;
    logic e;
    logic [2:0] s, d;
    logic [7:0] data;

    tbl[0] = '{1'b1, 3'd0, 3'd6, 8'hFC, 1'b0, 8'h00, 1'b1, 8'h40};
    tbl[1] = '{1'b0, 3'd0, 3'd7, 8'h00, 1'b0, 8'h01, 1'b0, 8'h80};
    tbl[2] = '{1'b0, 3'd4, 3'd4, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 3'd5, 3'd1, 8'h00, 1'b0, 8'h20, 1'b0, 8'h02};
    tbl[4] = '{1'b1, 3'd3, 3'd0, 8'h33, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[5] = '{1'b0, 3'd7, 3'd6, 8'h00, 1'b0, 8'h80, 1'b0, 8'h40};

    ill[0] = '{1'b0, 4'd1, 4'd8};
    ill[1] = '{1'b0, 4'd9, 4'd2};
    ill[2] = '{1'b0, 4'd15, 4'd15};

    rst = 1'b1;
    req_valid = 1'b0; req_ext = 1'b0; req_src = '0; req_dst = '0;
    req_valid2 = 1'b0; req_ext2 = 1'b0; req_src2 = '0; req_dst2 = '0;
    ext_data = 8'h00; load_en = 1'b0;
    for (int i = 0; i < 8; i++) load_val[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_oe", 32'(oe), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_flags", {29'd0, ext_oe, done, err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h1);

    // Table-driven single commands
    preload(8'h11);
    for (int t = 0; t < 6; t++) begin
      issue(tbl[t].ext, tbl[t].src, tbl[t].dst, tbl[t].data);
      if (tbl[t].trivial) begin
        check("triv_c1_done", 32'(done), 32'h1);
        check("triv_c1_strobes", {15'd0, ext_oe, oe, wr}, 32'h0);
        check("triv_c1_err", 32'(err), 32'h0);
        check("triv_c1_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("triv_c2_ready", 32'(req_ready), 32'h1);
      end else begin
        check("c1_oe", 32'(oe), 32'(tbl[t].exp_oe));
        check("c1_ext_oe", 32'(ext_oe), 32'(tbl[t].exp_ext));
        check("c1_wr", 32'(wr), 32'h0);
        check("c1_done", 32'(done), 32'h0);
        @(negedge clk);
        check("c2_oe", 32'(oe), 32'(tbl[t].exp_oe));
        check("c2_ext_oe", 32'(ext_oe), 32'(tbl[t].exp_ext));
        check("c2_wr", 32'(wr), 32'(tbl[t].exp_wr));
        @(negedge clk);
        check("c3_done", 32'(done), 32'h1);
        check("c3_undriven", {15'd0, ext_oe, oe, wr}, 32'h0);
        check("c3_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("c4_ready", 32'(req_ready), 32'h1);
      end
      model_apply(tbl[t].ext, tbl[t].src, tbl[t].dst, tbl[t].data);
    end
    for (int i = 0; i < 8; i++) check("tbl_rf", 32'(rf[i]), 32'(model[i]));

    // Back-to-back moves with req_valid held high: 0->7 then 7->3
    preload(8'h20);
    load_val[0] = 8'h5A;
    load_en = 1'b1;
    model[0] = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    req_valid = 1'b1; req_ext = 1'b0; req_src = 3'd0; req_dst = 3'd7;
    @(posedge clk);
    @(negedge clk);
    req_src = 3'd7; req_dst = 3'd3;
    k = 1;
    while (k < 10) begin
      if (k == 1) begin
        check("held_c1_oe", 32'(oe), 32'h01);
        check("held_c1_wr", 32'(wr), 32'h00);
      end
      if (k == 2) begin
        check("held_c2_oe", 32'(oe), 32'h01);
        check("held_c2_wr", 32'(wr), 32'h80);
      end
      if (k == 3) begin
        check("held_turn_undriven", {23'd0, ext_oe, oe}, 32'h0);
        check("held_turn_done", 32'(done), 32'h1);
      end
      if (req_ready) break;
      @(negedge clk);
      k++;
    end
    check("held_gap", 32'(k), 32'd4);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("held2_c1_oe", 32'(oe), 32'h80);
    repeat (3) @(negedge clk);
    check("held_rf7", 32'(rf[7]), 32'h5A);
    check("held_rf3", 32'(rf[3]), 32'h5A);
    model[7] = 8'h5A;
    model[3] = 8'h5A;

    // Reset during LATCH of 1->2
    preload(8'h40);
    issue(1'b0, 3'd1, 3'd2, 8'h00);
    @(negedge clk);
    check("rl_latch_wr", 32'(wr), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("rl_async_oe", 32'(oe), 32'h0);
    check("rl_async_wr", 32'(wr), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rl_ready", 32'(req_ready), 32'h1);
    k = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) k++;
      @(negedge clk);
    end
    check("rl_no_done", 32'(k), 32'd0);
    check("rl_rf2", 32'(rf[2]), 32'(model[2]));

    // Illegal commands on the IDX_W=4 instance
    for (int t = 0; t < 3; t++) begin
      issue2(ill[t].ext, ill[t].src, ill[t].dst);
      check("ill_done", 32'(done2), 32'h1);
      check("ill_err", 32'(err2), 32'h1);
      check("ill_strobes", {15'd0, ext_oe2, oe2, wr2}, 32'h0);
      @(negedge clk);
      check("ill_ready", 32'(req_ready2), 32'h1);
    end
    // External source ignores an out-of-range src index
    issue2(1'b1, 4'd12, 4'd3);
    check("ext12_c1", {15'd0, ext_oe2, oe2, wr2}, 32'h10000);
    @(negedge clk);
    check("ext12_c2_wr", 32'(wr2), 32'h08);
    @(negedge clk);
    check("ext12_c3", {30'd0, done2, err2}, 32'h2);

    // Random command stream
    preload(8'h03);
    for (int r = 0; r < 500; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = ($urandom_range(0, 3) == 0);
      s = 3'($urandom);
      d = ($urandom_range(0, 7) == 0) ? s : 3'($urandom);
      data = 8'($urandom);
      issue(e, s, d, data);
      k = 1;
      while (!done && k < 8) begin
        @(negedge clk);
        k++;
      end
      check("rand_done_lat", 32'(k), is_move(e, s, d) ? 32'd3 : 32'd1);
      model_apply(e, s, d, data);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) check("rand_rf", 32'(rf[i]), 32'(model[i]));
    check("invariants", 32'(viol), 32'd0);
    check("no_err_legal", 32'(err1_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
